// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin arbiter: N Avalon-ST sources share one sink.
// Grant is held sop..eop; over-long packets are cut with a forced eop and the remainder drained.
module ast_packet_arbiter #(
  parameter int AST_DWIDTH     = 64,
  parameter int N_PORTS        = 4,
  parameter int CHANNEL_WIDTH  = 2,
  parameter int MAX_PCKT_WORDS = 190,
  localparam int EMPTY_WIDTH   = $clog2(AST_DWIDTH/8)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [N_PORTS*AST_DWIDTH-1:0]  snk_data_i,
  input  logic [N_PORTS*EMPTY_WIDTH-1:0] snk_empty_i,
  input  logic [N_PORTS-1:0]             snk_sop_i,
  input  logic [N_PORTS-1:0]             snk_eop_i,
  input  logic [N_PORTS-1:0]             snk_valid_i,
  output logic [N_PORTS-1:0]             snk_ready_o,
  output logic [AST_DWIDTH-1:0]          src_data_o,
  output logic [EMPTY_WIDTH-1:0]         src_empty_o,
  output logic                           src_sop_o,
  output logic                           src_eop_o,
  output logic                           src_valid_o,
  output logic [CHANNEL_WIDTH-1:0]       src_channel_o,
  input  logic                           src_ready_i,
  output logic                           trunc_o,
  output logic                           orphan_o
);

  localparam int CW = $clog2(MAX_PCKT_WORDS+1);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

  state_t                 state, state_nxt;
  logic [PW-1:0]          grant, grant_nxt;
  logic [PW-1:0]          ptr, ptr_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;

  logic [N_PORTS-1:0]     cand;
  logic                   pick_found;
  logic [PW-1:0]          pick_idx;

  logic [AST_DWIDTH-1:0]  g_data;
  logic [EMPTY_WIDTH-1:0] g_empty;
  logic                   g_sop, g_eop, g_valid;

  logic                   out_rdy;
  logic                   load, force_eop, trunc_nxt, orphan_nxt;

  // Port index base+off, wrapping at N_PORTS (off < N_PORTS, base < N_PORTS).
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(off);
    if (sum >= (PW+1)'(N_PORTS))
      sum = sum - (PW+1)'(N_PORTS);
    return sum[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return (p == PW'(N_PORTS-1)) ? '0 : p + PW'(1);
  endfunction

  assign out_rdy = ~src_valid_o | src_ready_i;
  assign cand    = snk_valid_i & snk_sop_i;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!pick_found && cand[rr_index(ptr, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_index(ptr, i);
      end
    end
  end

  // Granted-port view of the sink bus.
  always_comb begin
    g_data  = '0;
    g_empty = '0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_valid = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant == PW'(p)) begin
        g_data  = snk_data_i[p*AST_DWIDTH +: AST_DWIDTH];
        g_empty = snk_empty_i[p*EMPTY_WIDTH +: EMPTY_WIDTH];
        g_sop   = snk_sop_i[p];
        g_eop   = snk_eop_i[p];
        g_valid = snk_valid_i[p];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    snk_ready_o = '0;
    load        = 1'b0;
    force_eop   = 1'b0;
    trunc_nxt   = 1'b0;
    orphan_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // Mid-packet words with no owner are swallowed so they cannot block the port.
        snk_ready_o = snk_valid_i & ~snk_sop_i;
        orphan_nxt  = |(snk_valid_i & ~snk_sop_i);
        if (pick_found) begin
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        snk_ready_o[grant] = out_rdy;
        if (g_valid && out_rdy) begin
          load    = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (g_eop) begin
            state_nxt = IDLE;
            ptr_nxt   = next_port(grant);
          end else if (cnt == CW'(MAX_PCKT_WORDS-1)) begin
            force_eop = 1'b1;
            trunc_nxt = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        snk_ready_o[grant] = 1'b1;
        if (g_valid && g_eop) begin
          state_nxt = IDLE;
          ptr_nxt   = next_port(grant);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      cnt      <= '0;
      trunc_o  <= 1'b0;
      orphan_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      trunc_o  <= trunc_nxt;
      orphan_o <= orphan_nxt;
    end
  end

  // Output slice stage: loads on an accepted word, otherwise drains when downstream takes it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_valid_o   <= 1'b0;
      src_data_o    <= '0;
      src_empty_o   <= '0;
      src_sop_o     <= 1'b0;
      src_eop_o     <= 1'b0;
      src_channel_o <= '0;
    end else if (load) begin
      src_valid_o   <= 1'b1;
      src_data_o    <= g_data;
      src_empty_o   <= force_eop ? '0 : g_empty;
      src_sop_o     <= g_sop;
      src_eop_o     <= g_eop | force_eop;
      src_channel_o <= CHANNEL_WIDTH'(grant);
    end else if (src_ready_i) begin
      src_valid_o   <= 1'b0;
    end
  end

endmodule
